// File: rtl/clk_enable_nco_pkg.sv
// Shared constants and sizing helpers for the clock-enable NCO block.
package clk_enable_nco_pkg;

  localparam int          NCO_ACC_W       = 32;
  localparam logic [31:0] NCO_DEFAULT_FTW = 32'h4000_0000;

  // Width of a counter that must hold 0 .. lock_cycles-1.
  function automatic int lock_cnt_w(input int lock_cycles);
    return (lock_cycles > 2) ? $clog2(lock_cycles) : 1;
  endfunction

  // Width of a channel index for n channels (never narrower than one bit).
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, carry-derived enable strobe, square
// output, and the point at which a pending retune takes effect.
module nco_channel
  import clk_enable_nco_pkg::*;
#(
  parameter int               ACC_W       = NCO_ACC_W,
  parameter logic [ACC_W-1:0] DEFAULT_FTW = ACC_W'(NCO_DEFAULT_FTW)
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             i_pend,
  input  logic [ACC_W-1:0] i_ftw,
  input  logic [ACC_W-1:0] i_phase,
  output logic             o_apply,
  output logic             o_en,
  output logic             o_sq
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_ftw;
  logic             r_en;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw};
  assign w_carry = w_sum[ACC_W];

  // A retune lands on a wrap so the output phase jumps cleanly; a stopped
  // channel never wraps, so it takes the new setting immediately instead.
  assign o_apply = i_pend && (w_carry || (r_ftw == '0));

  // Accumulate, strobe on carry, and swap in the pending setting on apply.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ftw <= DEFAULT_FTW;
      r_en  <= 1'b0;
    end else begin
      r_en <= w_carry;
      if (o_apply) begin
        r_acc <= i_phase;
        r_ftw <= i_ftw;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign o_en = r_en;
  assign o_sq = r_acc[ACC_W-1];

endmodule

// File: rtl/clk_enable_nco.sv
// Multi-channel clock-enable NCO: configuration handshake with a single
// pending slot, per-channel accumulators, and a settle counter for locked.
module clk_enable_nco
  import clk_enable_nco_pkg::*;
#(
  parameter int               NUM_CLOCKS  = 2,
  parameter int               ACC_W       = NCO_ACC_W,
  parameter int               LOCK_CYCLES = 256,
  parameter logic [ACC_W-1:0] DEFAULT_FTW = ACC_W'(NCO_DEFAULT_FTW)
) (
  input  logic                            refclk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [chan_w(NUM_CLOCKS)-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]                cfg_ftw,
  input  logic [ACC_W-1:0]                cfg_phase,
  output logic [NUM_CLOCKS-1:0]           outclk_en,
  output logic [NUM_CLOCKS-1:0]           outclk_sq,
  output logic                            locked
);

  localparam int               CHAN_W   = chan_w(NUM_CLOCKS);
  localparam int               CNT_W    = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic                  r_ready;
  logic                  r_pend;
  logic [CHAN_W-1:0]     r_pchan;
  logic [ACC_W-1:0]      r_pftw;
  logic [ACC_W-1:0]      r_pphase;
  logic                  r_locked;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_CLOCKS-1:0] w_apply;
  logic                  w_apply_any;
  logic                  w_chan_ok;
  logic                  w_take;

  // Out-of-range channel requests are acknowledged but otherwise ignored.
  assign w_chan_ok   = (int'(cfg_chan) < NUM_CLOCKS);
  assign w_take      = cfg_valid && r_ready && w_chan_ok;
  assign w_apply_any = |w_apply;

  // Handshake, pending-slot occupancy and settle counter. The edge that
  // frees the slot (or the first edge out of reset) is the anchor from
  // which LOCK_CYCLES further edges are counted before locked rises.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready  <= 1'b0;
      r_pend   <= 1'b0;
      r_locked <= 1'b0;
      r_cnt    <= '0;
    end else if (w_take) begin
      r_pend   <= 1'b1;
      r_ready  <= 1'b0;
      r_locked <= 1'b0;
      r_cnt    <= '0;
    end else if (r_pend) begin
      if (w_apply_any) begin
        r_pend  <= 1'b0;
        r_ready <= 1'b1;
      end
    end else begin
      r_ready <= 1'b1;
      if (r_ready && !r_locked) begin
        if (r_cnt == CNT_LAST) begin
          r_locked <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Pending payload; only meaningful while r_pend is set, so no reset.
  always_ff @(posedge refclk) begin
    if (w_take) begin
      r_pchan  <= cfg_chan;
      r_pftw   <= cfg_ftw;
      r_pphase <= cfg_phase;
    end
  end

  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
    logic w_sel;
    assign w_sel = r_pend && (r_pchan == CHAN_W'(gi));

    nco_channel #(
      .ACC_W      (ACC_W),
      .DEFAULT_FTW(DEFAULT_FTW)
    ) u_chan (
      .refclk (refclk),
      .rst_n  (rst_n),
      .i_pend (w_sel),
      .i_ftw  (r_pftw),
      .i_phase(r_pphase),
      .o_apply(w_apply[gi]),
      .o_en   (outclk_en[gi]),
      .o_sq   (outclk_sq[gi])
    );
  end

  assign cfg_ready = r_ready;
  assign locked    = r_locked;

endmodule
